// File: rtl/lucas_seq_if.sv
// Request/result bundle for the generalised Lucas-sequence engine.
interface lucas_seq_if #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
);
    logic                    go;
    logic [INPUT_WIDTH-1:0]  n;
    logic [OUTPUT_WIDTH-1:0] seed0;
    logic [OUTPUT_WIDTH-1:0] seed1;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    overflow;
    logic                    done;
    logic                    busy;

    // Requester side: issues go/n/seeds and consumes the result.
    modport master (
        output go, n, seed0, seed1,
        input  result, overflow, done, busy
    );

    // Engine side.
    modport slave (
        input  go, n, seed0, seed1,
        output result, overflow, done, busy
    );
endinterface

// File: rtl/lucas_seq.sv
// Iterative T(k) = T(k-1) + T(k-2) engine with programmable seeds.
// One addition per clock; optional saturation on overflow.
module lucas_seq #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter bit SATURATE     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    lucas_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [INPUT_WIDTH-1:0]  n_q, n_d;
    logic [INPUT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] x_q, x_d;
    logic [OUTPUT_WIDTH-1:0] y_q, y_d;
    logic [OUTPUT_WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;

    // One bit wider than the operands so the carry is visible.
    logic [OUTPUT_WIDTH:0]   sum;
    logic                    ovf_next;

    // Next-state and datapath: latch on go, step x/y once per cycle, load result on exit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        sum      = {1'b0, x_q} + {1'b0, y_q};
        ovf_next = ovf_q | sum[OUTPUT_WIDTH];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.go) begin
                    n_d     = bus.n;
                    x_d     = bus.seed0;
                    y_d     = bus.seed1;
                    cnt_d   = INPUT_WIDTH'(1);
                    ovf_d   = 1'b0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // cnt never passes n_q, so it cannot wrap even for n = all-ones.
                if (cnt_q >= n_q) begin
                    // With n = 0 no addition ran, so x still holds seed0.
                    result_d = (n_q == '0) ? x_q : y_q;
                    state_d  = S_DONE;
                end else begin
                    ovf_d = ovf_next;
                    x_d   = y_q;
                    y_d   = (SATURATE && ovf_next) ? '1 : sum[OUTPUT_WIDTH-1:0];
                    cnt_d = cnt_q + INPUT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = (state_q == S_DONE);
    assign bus.busy     = (state_q == S_COMPUTE);

endmodule

// File: doc/lucas_seq.md
LUCAS_SEQ -- requirements
Module: lucas_seq

Interface
REQ-001 Parameter INPUT_WIDTH, default 6, sets the bit width of n.
REQ-002 Parameter OUTPUT_WIDTH, default 32, sets the bit width of seed0, seed1 and result.
REQ-003 Parameter SATURATE, default 0: 0 = wrap modulo 2^OUTPUT_WIDTH on overflow; 1 = clamp to all-ones.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 go  in  1  start request, active-high, sampled on the rising edge.
REQ-007 n  in  INPUT_WIDTH  index of the requested term, unsigned.
REQ-008 seed0  in  OUTPUT_WIDTH  term T(0), unsigned.
REQ-009 seed1  in  OUTPUT_WIDTH  term T(1), unsigned.
REQ-010 result  out  OUTPUT_WIDTH  T(n); valid while done=1.
REQ-011 overflow  out  1  sticky flag: an addition in the current computation exceeded OUTPUT_WIDTH bits; valid while done=1.
REQ-012 done  out  1  result and overflow are valid.
REQ-013 busy  out  1  a computation is in progress.

Function
REQ-014 The block SHALL compute T(n), where T(k) = T(k-1) + T(k-2) for k>=2, with T(0)=seed0 and T(1)=seed1.
REQ-015 The FSM SHALL have three states: IDLE, COMPUTE and DONE; busy=1 exactly in COMPUTE.
REQ-016 A go=1 edge in IDLE or DONE SHALL latch n, seed0 and seed1, clear done and overflow on that edge, and enter COMPUTE.
REQ-017 go=1 in COMPUTE SHALL be ignored.
REQ-018 Changes to n or the seeds after the latching edge SHALL NOT affect the running computation.
REQ-019 COMPUTE SHALL perform one addition per cycle (x<=y, y<=x+y) under an index counter initialised to 1.
REQ-020 COMPUTE SHALL exit to DONE when the counter >= latched n.
REQ-021 On the exit edge, result SHALL be loaded with seed0 if n=0, otherwise with the current y, and done SHALL be set to 1.
REQ-022 Latency: done SHALL rise max(n,1) clock edges after the go edge, with exactly max(n,1)-1 additions performed.
REQ-023 The counter SHALL be INPUT_WIDTH bits and SHALL NOT wrap, for every n up to 2^INPUT_WIDTH-1.
REQ-024 Each addition SHALL be OUTPUT_WIDTH+1 bits wide; a carry out SHALL set overflow, which stays set until the next accepted go or rst.
REQ-025 With SATURATE=1, once any carry occurs, y and every later sum SHALL hold all-ones, so result = 2^OUTPUT_WIDTH-1.
REQ-026 With SATURATE=0, sums SHALL wrap modulo 2^OUTPUT_WIDTH.
REQ-027 n<=1 SHALL perform no addition and SHALL never set overflow.
REQ-028 In DONE, result, overflow and done=1 SHALL hold indefinitely until the next go.
REQ-029 done SHALL read 0 in the cycle after an accepted go edge.
REQ-030 go held high continuously SHALL restart the computation on every DONE entry, so done is high for exactly one cycle per computation.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and set result=0, overflow=0, done=0 and busy=0, independent of clk, aborting any computation.
REQ-032 rst SHALL take priority over a simultaneous go; the first go sampled after rst deasserts starts a computation.

Verification
REQ-033 seeds 0,1, n=10, go 1 cycle -> done rises 10 edges after go; result=55, overflow=0, busy=1 for 10 cycles.
REQ-034 seeds 7,9: n=0 -> result=7; n=1 -> result=9; done 1 edge after go in both cases, overflow=0.
REQ-035 seeds 2,1 (Lucas), n=5 -> result=11; then n=0 -> result=2.
REQ-036 OUTPUT_WIDTH=8, seeds 0,1: n=13 -> result=233, overflow=0. n=14 with SATURATE=0 -> result=121, overflow=1. n=14 with SATURATE=1 -> result=255, overflow=1.
REQ-037 n=20 started, then go pulsed and n changed to 3 mid-COMPUTE -> result=6765 at edge 20; rst mid-COMPUTE -> all outputs 0 at once, and no done follows.
REQ-038 Back-to-back: go asserted in the first DONE cycle after an overflowing run -> done=0 and overflow=0 next cycle; the new correct result follows at the specified latency.
